// File: rtl/config_scan_loader_pkg.sv
// Shared definitions for the CLB configuration scan loader: CLB geometry,
// the derived chain length, words-per-load helper and the loader FSM states.
package config_scan_loader_pkg;

  localparam int CLB_IN_WIDTH   = 4;
  localparam int CONN_SEL_WIDTH = 3;

  // is_comb bit + connection-mux selects + LUT SRAM
  localparam int DEF_CHAIN_LEN  = CONN_SEL_WIDTH * CLB_IN_WIDTH + 2**CLB_IN_WIDTH + 1;
  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 5;

  // Host words needed to cover the whole chain
  function automatic int num_words(input int chain_len, input int word_width);
    return (chain_len + word_width - 1) / word_width;
  endfunction

  localparam int DEF_NUM_WORDS = num_words(DEF_CHAIN_LEN, DEF_WORD_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } load_state_t;

endpackage

// File: rtl/config_scan_loader_cfg_word_serializer.sv
// Parallel-load PISO for one host configuration word, LSB out first.
// bit_idx counts bits shifted out since the last load.
module cfg_word_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  sout,
  output logic [IDX_WIDTH-1:0]  bit_idx
);

  logic [WORD_WIDTH-1:0] sreg;

  // Load a fresh word or move the next bit into position 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sreg    <= data;
      bit_idx <= '0;
    end else if (shift) begin
      sreg    <= sreg >> 1;
      bit_idx <= bit_idx + IDX_WIDTH'(1);
    end
  end

  assign sout = sreg[0];

endmodule

// File: rtl/config_scan_loader.sv
// Bitstream loader feeding the CLB configuration scan chain. Host words are
// accepted over valid/ready and serialised LSB-first onto chain_sin while
// chain_sen is high; exactly CHAIN_LEN bits are shifted per load.
// Optional feature: define CONFIG_VERIFY_EN to add a recirculating readback
// pass that compares load parity against chain_sout parity.
module config_scan_loader
  import config_scan_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  chain_sin,
  output logic                  chain_sen,
  input  logic                  chain_sout,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_err
);

  localparam int IDX_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORD_WIDTH - 1);

  load_state_t          state;
  logic [CNT_WIDTH-1:0] bit_cnt;
  logic                 ser_load;
  logic                 ser_shift;
  logic                 ser_bit;
  logic [IDX_WIDTH-1:0] bit_idx;

  assign ser_load  = (state == ST_WAIT_WORD) && cfg_valid && cfg_ready;
  assign ser_shift = (state == ST_SHIFT);

  cfg_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .data    (cfg_data),
    .sout    (ser_bit),
    .bit_idx (bit_idx)
  );

`ifdef CONFIG_VERIFY_EN
  logic                 load_par;
  logic                 rb_par;
  logic [CNT_WIDTH-1:0] vfy_cnt;
`endif

  // Loader FSM with registered handshake, chain-enable and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cfg_ready  <= 1'b0;
      chain_sen  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_cnt    <= '0;
`ifdef CONFIG_VERIFY_EN
      verify_err <= 1'b0;
      load_par   <= 1'b0;
      rb_par     <= 1'b0;
      vfy_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_WAIT_WORD;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_cnt   <= '0;
`ifdef CONFIG_VERIFY_EN
            verify_err <= 1'b0;
            load_par   <= 1'b0;
            rb_par     <= 1'b0;
            vfy_cnt    <= '0;
`endif
          end
        end
        ST_WAIT_WORD: begin
          if (ser_load) begin
            state     <= ST_SHIFT;
            cfg_ready <= 1'b0;
            chain_sen <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_WIDTH'(1);
`ifdef CONFIG_VERIFY_EN
          load_par <= load_par ^ ser_bit;
`endif
          // Chain completion wins over word completion, so surplus bits of
          // the final word are never shifted
          if (bit_cnt == LAST_BIT) begin
`ifdef CONFIG_VERIFY_EN
            state <= ST_VERIFY;
`else
            state     <= ST_DONE;
            chain_sen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end else if (bit_idx == LAST_IDX) begin
            state     <= ST_WAIT_WORD;
            chain_sen <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
`ifdef CONFIG_VERIFY_EN
        ST_VERIFY: begin
          rb_par  <= rb_par ^ chain_sout;
          vfy_cnt <= vfy_cnt + CNT_WIDTH'(1);
          if (vfy_cnt == LAST_BIT) begin
            state      <= ST_DONE;
            chain_sen  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            // Fold in the final readback bit that rb_par has not seen yet
            verify_err <= load_par ^ rb_par ^ chain_sout;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b0;
          chain_sen <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONFIG_VERIFY_EN
  // Recirculate the chain during readback so its contents are restored
  assign chain_sin = (state == ST_VERIFY) ? chain_sout : (chain_sen & ser_bit);
`else
  logic unused_sout;
  assign unused_sout = chain_sout;
  assign chain_sin   = chain_sen & ser_bit;
  assign verify_err  = 1'b0;
`endif

endmodule
